// File: rtl/riscv_v_result_pipe_pkg.sv
// Shared types for the vector result pipe: register-file write bundle carried by each stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_v_pkg;

    localparam int VLEN = 128;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [VLEN-1:0]   riscv_v_data_t;
    typedef logic [VLEN/8-1:0] riscv_v_rf_wr_en_t;
    typedef logic [AW-1:0]     riscv_instr_rd_t;

    // All-zero enables mark a bubble; addr/data are then don't-care but kept at zero.
    typedef struct packed {
        riscv_v_rf_wr_en_t en;
        riscv_instr_rd_t   addr;
        riscv_v_data_t     data;
    } riscv_v_result_stage_t;

endpackage

// File: rtl/riscv_v_result_pipe_if.sv
// Execute-to-result-pipe handshake bundle: the execute stage is master, the pipe is slave.
// Latency: n/a (wires only).
// Backpressure: ready_exe driven by the slave.
interface riscv_v_result_pipe_if #(
    parameter int VLEN = 128,
    parameter int NREG = 32
);
    logic                    valid_exe;
    logic                    ready_exe;
    logic [VLEN-1:0]         alu_result_exe;
    logic [VLEN-1:0]         mask_result_exe;
    logic [VLEN/8-1:0]       rf_wr_en_exe;
    logic [$clog2(NREG)-1:0] rf_wr_addr_exe;
    logic                    is_mask_exe;

    modport master (
        output valid_exe, alu_result_exe, mask_result_exe, rf_wr_en_exe,
               rf_wr_addr_exe, is_mask_exe,
        input  ready_exe
    );

    modport slave (
        input  valid_exe, alu_result_exe, mask_result_exe, rf_wr_en_exe,
               rf_wr_addr_exe, is_mask_exe,
        output ready_exe
    );
endinterface

// File: rtl/riscv_v_result_pipe_stage.sv
// One result-pipe stage register with hold and bubble insertion.
// Latency: 1 cycle.
// Backpressure: hold freezes contents; kill loads a bubble instead of d.
module riscv_v_result_stage
    import riscv_v_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  kill,
    input  riscv_v_result_stage_t d,
    output riscv_v_result_stage_t q
);

    // hold wins over kill so a frozen stage also ignores squash requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (!hold)
            q <= kill ? '0 : d;
    end

endmodule

// File: rtl/riscv_v_result_pipe.sv
// Vector result pipe: execute result -> mem -> wb, with bypass taps and one-shot RF write.
// Latency: 2 cycles from transfer to wb; mask routing enabled by macro RISCV_V_MASK_WB_EN.
// Backpressure: ready_exe = !stall; stall freezes mem and wb, and the wb entry writes only once.
module riscv_v_result_pipe #(
    parameter int VLEN = riscv_v_pkg::VLEN,
    parameter int NREG = riscv_v_pkg::NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    riscv_v_result_pipe_if.slave    exe,
    input  logic                    stall,
    input  logic                    flush,
    output logic [VLEN/8-1:0]       rf_wr_en_mem,
    output logic [$clog2(NREG)-1:0] rf_wr_addr_mem,
    output logic [VLEN-1:0]         rf_wr_data_mem,
    output logic [VLEN/8-1:0]       rf_wr_en_wb,
    output logic [$clog2(NREG)-1:0] rf_wr_addr_wb,
    output logic [VLEN-1:0]         rf_wr_data_wb,
    output logic [VLEN/8-1:0]       rf_we,
    output logic [31:0]             wr_count
);
    import riscv_v_pkg::*;

    localparam int EW = VLEN / 8;

    logic                  xfer;
    logic                  wb_done;
    logic                  wb_fire;
    riscv_v_result_stage_t mem_d;
    riscv_v_result_stage_t mem_q;
    riscv_v_result_stage_t wb_q;

    assign exe.ready_exe = !stall;
    assign xfer          = exe.valid_exe && !stall;

    always_comb begin
        mem_d.en   = exe.rf_wr_en_exe;
        mem_d.addr = exe.rf_wr_addr_exe;
        mem_d.data = exe.alu_result_exe;
`ifdef RISCV_V_MASK_WB_EN
        // Mask results always land in v0.
        if (exe.is_mask_exe) begin
            mem_d.addr = '0;
            mem_d.data = exe.mask_result_exe;
        end
`endif
    end

`ifndef RISCV_V_MASK_WB_EN
    logic unused_mask;
    assign unused_mask = ^{exe.is_mask_exe, exe.mask_result_exe};
`endif

    riscv_v_result_stage u_mem (
        .clk  (clk),
        .rst  (rst),
        .hold (stall),
        .kill (!xfer || flush),
        .d    (mem_d),
        .q    (mem_q)
    );

    riscv_v_result_stage u_wb (
        .clk  (clk),
        .rst  (rst),
        .hold (stall),
        .kill (1'b0),
        .d    (mem_q),
        .q    (wb_q)
    );

    assign rf_wr_en_mem   = mem_q.en;
    assign rf_wr_addr_mem = mem_q.addr;
    assign rf_wr_data_mem = mem_q.data;
    assign rf_wr_en_wb    = wb_q.en;
    assign rf_wr_addr_wb  = wb_q.addr;
    assign rf_wr_data_wb  = wb_q.data;

    assign wb_fire = (|wb_q.en) && !wb_done;
    assign rf_we   = {EW{wb_fire}};

    // wb reloads on every unstalled edge, so that is where the write-once flag clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wb_done <= 1'b0;
        else if (!stall)
            wb_done <= 1'b0;
        else if (wb_fire)
            wb_done <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_count <= '0;
        else if (wb_fire)
            wr_count <= wr_count + 32'd1;
    end

endmodule

// File: tb/tb_riscv_v_result_pipe.sv
// Directed bench for riscv_v_result_pipe: vector table plus stall, wrap and reset sequences.
module tb_riscv_v_result_pipe;

    localparam int VLEN = 128;
    localparam int NREG = 32;
    localparam logic [15:0]  ONES = 16'hFFFF;
    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_3C = {16{8'h3C}};
    localparam logic [127:0] D_11 = {16{8'h11}};
    localparam logic [127:0] D_22 = {16{8'h22}};
    localparam logic [127:0] D_44 = {16{8'h44}};
    localparam logic [127:0] D_66 = {16{8'h66}};
    localparam logic [127:0] D_FF = {16{8'hFF}};
    localparam logic [127:0] D_0F = {16{8'h0F}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic [15:0]  rf_wr_en_mem, rf_wr_en_wb, rf_we;
    logic [4:0]   rf_wr_addr_mem, rf_wr_addr_wb;
    logic [127:0] rf_wr_data_mem, rf_wr_data_wb;
    logic [31:0]  wr_count;

    int checks = 0;
    int errors = 0;

    riscv_v_result_pipe_if #(.VLEN(VLEN), .NREG(NREG)) exe_if ();

    riscv_v_result_pipe #(.VLEN(VLEN), .NREG(NREG)) dut (
        .clk            (clk),
        .rst            (rst),
        .exe            (exe_if.slave),
        .stall          (stall),
        .flush          (flush),
        .rf_wr_en_mem   (rf_wr_en_mem),
        .rf_wr_addr_mem (rf_wr_addr_mem),
        .rf_wr_data_mem (rf_wr_data_mem),
        .rf_wr_en_wb    (rf_wr_en_wb),
        .rf_wr_addr_wb  (rf_wr_addr_wb),
        .rf_wr_data_wb  (rf_wr_data_wb),
        .rf_we          (rf_we),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid, flush, is_mask;
        logic [4:0]   addr;
        logic [15:0]  en;
        logic [127:0] alu, mask;
        logic [15:0]  m_en;
        logic [4:0]   m_addr;
        logic [127:0] m_data;
        logic [15:0]  w_en;
        logic [4:0]   w_addr;
        logic [127:0] w_data;
        logic [15:0]  we;
        logic [31:0]  cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic v, f, m, input logic [4:0] a, input logic [15:0] e,
                                input logic [127:0] alu, mk_d,
                                input logic [15:0] me, input logic [4:0] ma, input logic [127:0] md,
                                input logic [15:0] we_, input logic [4:0] wa, input logic [127:0] wd,
                                input logic [15:0] rwe, input logic [31:0] c);
        vec_t r;
        r.valid = v; r.flush = f; r.is_mask = m; r.addr = a; r.en = e; r.alu = alu; r.mask = mk_d;
        r.m_en = me; r.m_addr = ma; r.m_data = md;
        r.w_en = we_; r.w_addr = wa; r.w_data = wd; r.we = rwe; r.cnt = c;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [127:0] d);
        exe_if.valid_exe       = v;
        exe_if.rf_wr_addr_exe  = a;
        exe_if.rf_wr_en_exe    = v ? ONES : 16'h0;
        exe_if.alu_result_exe  = d;
        exe_if.mask_result_exe = '0;
        exe_if.is_mask_exe     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, rf_wr_en_mem, 0);
        chk({tag, "_mem_addr"}, rf_wr_addr_mem, 0);
        chk({tag, "_mem_data"}, rf_wr_data_mem, 0);
        chk({tag, "_wb_en"}, rf_wr_en_wb, 0);
        chk({tag, "_wb_addr"}, rf_wr_addr_wb, 0);
        chk({tag, "_wb_data"}, rf_wr_data_wb, 0);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_count"}, wr_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]   ma;
        logic [127:0] md;
        int           we_hits;
`ifdef RISCV_V_MASK_WB_EN
        ma = 5'd0; md = D_0F;
`else
        ma = 5'd7; md = D_FF;
`endif
        //          v f m addr en       alu   mask  | mem en/addr/data  | wb en/addr/data      | we   cnt
        vecs[0]  = mk(1,0,0, 5, ONES,    D_A5, 0,    ONES,    5, D_A5,  0,       0, 0,     0,    0);
        vecs[1]  = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     ONES,    5, D_A5,  ONES, 0);
        vecs[2]  = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     0,       0, 0,     0,    1);
        vecs[3]  = mk(1,1,0, 3, ONES,    D_3C, 0,    0,       0, 0,     0,       0, 0,     0,    1);
        vecs[4]  = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     0,       0, 0,     0,    1);
        vecs[5]  = mk(1,0,0, 9, 16'h00FF,D_11, 0,    16'h00FF,9, D_11,  0,       0, 0,     0,    1);
        vecs[6]  = mk(1,0,0, 9, ONES,    D_22, 0,    ONES,    9, D_22,  16'h00FF,9, D_11,  ONES, 1);
        vecs[7]  = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     ONES,    9, D_22,  ONES, 2);
        vecs[8]  = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     0,       0, 0,     0,    3);
        vecs[9]  = mk(1,0,1, 7, ONES,    D_FF, D_0F, ONES,    ma,md,    0,       0, 0,     0,    3);
        vecs[10] = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     ONES,    ma,md,    ONES, 3);
        vecs[11] = mk(0,0,0, 0, 0,       0,    0,    0,       0, 0,     0,       0, 0,     0,    4);

        drive(0, 0, 0);
        #1;
        chk_all_zero("reset");
        chk("reset_ready", exe_if.ready_exe, 1);
        step(); step();
        rst = 1'b0;
        step();
        chk_all_zero("post_reset_idle");

        foreach (vecs[i]) begin
            exe_if.valid_exe       = vecs[i].valid;
            flush                  = vecs[i].flush;
            exe_if.is_mask_exe     = vecs[i].is_mask;
            exe_if.rf_wr_addr_exe  = vecs[i].addr;
            exe_if.rf_wr_en_exe    = vecs[i].en;
            exe_if.alu_result_exe  = vecs[i].alu;
            exe_if.mask_result_exe = vecs[i].mask;
            #1;
            chk($sformatf("v%0d_ready", i), exe_if.ready_exe, 1);
            step();
            chk($sformatf("v%0d_mem_en", i), rf_wr_en_mem, vecs[i].m_en);
            chk($sformatf("v%0d_mem_addr", i), rf_wr_addr_mem, vecs[i].m_addr);
            chk($sformatf("v%0d_mem_data", i), rf_wr_data_mem, vecs[i].m_data);
            chk($sformatf("v%0d_wb_en", i), rf_wr_en_wb, vecs[i].w_en);
            chk($sformatf("v%0d_wb_addr", i), rf_wr_addr_wb, vecs[i].w_addr);
            chk($sformatf("v%0d_wb_data", i), rf_wr_data_wb, vecs[i].w_data);
            chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].we);
            chk($sformatf("v%0d_count", i), wr_count, vecs[i].cnt);
        end
        flush = 1'b0;

        // Stall with a live entry in both mem and wb; flush and valid must be ignored.
        drive(1, 4, D_44);
        step();
        drive(1, 6, D_66);
        step();
        chk("stall_pre_wb_addr", rf_wr_addr_wb, 4);
        chk("stall_pre_mem_addr", rf_wr_addr_mem, 6);
        chk("stall_pre_rf_we", rf_we, ONES);
        stall = 1'b1;
        flush = 1'b1;
        drive(1, 1, D_11);
        #1;
        chk("stall_ready", exe_if.ready_exe, 0);
        we_hits = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (rf_we != 0) we_hits++;
            chk($sformatf("stall%0d_wb_addr", c), rf_wr_addr_wb, 4);
            chk($sformatf("stall%0d_wb_data", c), rf_wr_data_wb, D_44);
            chk($sformatf("stall%0d_wb_en", c), rf_wr_en_wb, ONES);
            chk($sformatf("stall%0d_mem_addr", c), rf_wr_addr_mem, 6);
            chk($sformatf("stall%0d_mem_en", c), rf_wr_en_mem, ONES);
        end
        chk("stall_extra_we", we_hits, 0);
        chk("stall_count", wr_count, 5);
        stall = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0);
        step();
        chk("unstall_wb_addr", rf_wr_addr_wb, 6);
        chk("unstall_rf_we", rf_we, ONES);
        chk("unstall_mem_en", rf_wr_en_mem, 0);
        step();
        chk("unstall_count", wr_count, 6);

        // Counter wrap.
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        #1;
        chk("wrap_preload", wr_count, 32'hFFFF_FFFF);
        drive(1, 2, D_3C);
        step();
        drive(0, 0, 0);
        step();
        chk("wrap_rf_we", rf_we, ONES);
        step();
        chk("wrap_count", wr_count, 0);

        // Reset mid-operation with entries in mem and wb.
        drive(1, 8, D_A5);
        step();
        drive(1, 10, D_3C);
        step();
        chk("rst_pre_wb_addr", rf_wr_addr_wb, 8);
        chk("rst_pre_mem_addr", rf_wr_addr_mem, 10);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        chk("async_rst_ready", exe_if.ready_exe, 1);
        stall = 1'b1;
        #1;
        chk("rst_ready_follows_stall", exe_if.ready_exe, 0);
        stall = 1'b0;
        step(); step();
        rst = 1'b0;
        drive(0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("post_rst%0d_rf_we", c), rf_we, 0);
            chk($sformatf("post_rst%0d_count", c), wr_count, 0);
        end
        drive(1, 12, D_22);
        step();
        drive(0, 0, 0);
        chk("post_rst_xfer_mem_addr", rf_wr_addr_mem, 12);
        chk("post_rst_xfer_wb_en", rf_wr_en_wb, 0);
        step();
        chk("post_rst_xfer_wb_addr", rf_wr_addr_wb, 12);
        chk("post_rst_xfer_wb_data", rf_wr_data_wb, D_22);
        chk("post_rst_xfer_rf_we", rf_we, ONES);
        step();
        chk("post_rst_xfer_count", wr_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_v_result_pipe.md
RISCV_V_RESULT_PIPE -- requirements
Module: riscv_v_result_pipe

Interface
REQ-001 Parameter VLEN, default 128: vector register width in bits; must be a multiple of 8.
REQ-002 Parameter NREG, default 32: number of vector registers; address width is log2(NREG).
REQ-003 Clocking and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- valid_exe  in  1  execute stage holds a result.
- ready_exe  out  1  result pipe accepts the execute result.
- alu_result_exe  in  VLEN  vector result.
- mask_result_exe  in  VLEN  mask result.
- rf_wr_en_exe  in  VLEN/8  per-byte write enables.
- rf_wr_addr_exe  in  log2(NREG)  destination register.
- is_mask_exe  in  1  result targets v0 as a mask.
- stall  in  1  freeze the mem and wb stages.
- flush  in  1  kill the incoming execute result.
- rf_wr_en_mem  out  VLEN/8  mem-stage byte enables (bypass).
- rf_wr_addr_mem  out  log2(NREG)  mem-stage destination (bypass).
- rf_wr_data_mem  out  VLEN  mem-stage data (bypass).
- rf_wr_en_wb  out  VLEN/8  wb-stage byte enables (bypass).
- rf_wr_addr_wb  out  log2(NREG)  wb-stage destination (bypass).
- rf_wr_data_wb  out  VLEN  wb-stage data (bypass).
- rf_we  out  VLEN/8  register-file write strobe, one-shot.
- wr_count  out  32  count of retired register-file writes.

Function
REQ-005 Handshake: ready_exe = !stall; a transfer occurs when valid_exe && ready_exe.
REQ-006 On a transfer with !flush, the mem stage captures enables, address and data on the next clk edge.
- Captured data = mask_result_exe when is_mask_exe, else alu_result_exe.
- Captured address = 0 when is_mask_exe.
REQ-007 With no transfer, or with flush, while !stall, the mem stage loads a bubble: enables all zero, data and address don't-care but held at zero.
REQ-008 While !stall, the wb stage loads the mem stage contents on each clk edge; latency from transfer to wb occupancy is 2 cycles.
REQ-009 While stall is high, the mem and wb registers hold their values and flush is ignored.
REQ-010 Bypass outputs (*_mem, *_wb) equal the stage registers directly, and remain valid during stall.
REQ-011 Write-once flag `wb_done`:
- rf_we = rf_wr_en_wb && !wb_done, with the same value on every byte lane.
- wb_done sets on the edge after rf_we is nonzero.
- wb_done clears whenever wb loads new contents.
- Consequence: a stalled wb entry writes the register file exactly once.
REQ-012 wr_count increments by 1 on each cycle where rf_we is nonzero, and wraps from 0xFFFFFFFF to 0.
REQ-013 A wb entry with all-zero enables never asserts rf_we and is not counted.
REQ-014 Back-to-back transfers to the same address both retire, in order, with no merging.

Reset
REQ-015 While rst is high, all of the following are zero: mem and wb registers, wb_done, wr_count, rf_we, and all bypass outputs; ready_exe follows stall.
REQ-016 Reset asserted mid-operation discards in-flight entries with no rf_we pulse; the first transfer after reset deasserts reaches wb 2 cycles later.

Configuration
REQ-017 Macro RISCV_V_MASK_WB_EN defined: is_mask_exe selects the mask data and address 0 as in REQ-006.
REQ-018 Macro RISCV_V_MASK_WB_EN undefined:
- The is_mask_exe port still exists but is ignored.
- mask_result_exe is unused.
- All results take alu_result_exe and rf_wr_addr_exe.

Structure
REQ-019 riscv_v_pkg holds the following; the stage struct carries the en, addr and data fields:
- VLEN and NREG constants;
- riscv_v_data_t, riscv_v_rf_wr_en_t, riscv_instr_rd_t;
- the new riscv_v_result_stage_t struct.
REQ-020 The design uses one sub-module, riscv_v_result_stage: a stage register with hold (stall) and bubble-insert (kill) inputs, instantiated twice.

Verification
REQ-021 Transfer with the following inputs, no stall, no flush:
- addr=5, en=all-ones, data=0xA5 repeated.
- Required: rf_wr_addr_mem=5 at cycle +1; rf_we=all-ones and addr_wb=5 at cycle +2; wr_count=1.
REQ-022 A transfer with flush=1 → mem enables=0 at cycle +1, no rf_we, wr_count unchanged.
REQ-023 Entry in wb, then stall held 4 cycles → rf_we nonzero only in the first cycle, bypass wb outputs constant, wr_count +1.
REQ-024 With the macro defined: is_mask_exe=1, addr=7, mask=0x0F, alu=0xFF → wb addr=0, data=0x0F. With the macro undefined → addr=7, data=0xFF.
REQ-025 Preload wr_count=0xFFFFFFFF via force, retire one write → wr_count=0.
REQ-026 Assert rst with entries in mem and wb → all outputs zero immediately, no rf_we after release.
